custom_pio_ctrl: RTL and testbench

- Avalon-MM slave controller for the 8-bit bidirectional custom PIO bank exported as custom_pio_new_signal.
- Provides per-bit direction control, output set/clear, synchronized input sampling, rising-edge capture with a masked interrupt, and a hardware blink sequencer driven by a programmable prescaler.
- The top level instantiates the tri-state buffers: pin = pio_oe[i] ? pio_out[i] : 'z; pio_in = pin.

---
 rtl/custom_pio_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_custom_pio_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_pio_ctrl.sv
// custom_pio_ctrl
//   Avalon-MM slave that controls the 8-bit bidirectional custom PIO bank.
//   It provides per-bit direction control, output set and clear, synchronized
//   input sampling, rising-edge capture with a masked level interrupt, and a
//   blink sequencer that toggles selected output bits every BLINK_PERIOD
//   cycles. The tri-state pad (pin = pio_oe ? pio_out : 'z) sits outside this
//   block. Every pin-facing output comes straight from a flop.
//
// Ports
//   clk_clk            system clock
//   reset_reset_n      asynchronous active-low reset
//   avs_address[2:0]   word address
//   avs_read           read strobe
//   avs_write          write strobe
//   avs_writedata[31:0]
//   avs_readdata[31:0] read data, one cycle after avs_read
//   avs_readdatavalid  qualifies avs_readdata
//   pio_in[WIDTH]      raw (asynchronous) pin inputs
//   pio_out[WIDTH]     output drive values
//   pio_oe[WIDTH]      output enable, 1 = drive
//   irq                level interrupt, |(EDGE & IRQ_MASK)
//
// Register map (word address)
//   0 DATA        rd: synchronized pins   wr: output register
//   1 DIR         rd/wr
//   2 IRQ_MASK    rd/wr
//   3 EDGE        rd: captured rising edges, wr: 1 clears
//   4 OUTSET      wr: 1 sets output bits, reads 0
//   5 OUTCLR      wr: 1 clears output bits, reads 0
//   6 BLINK_EN    rd/wr
//   7 BLINK_PERIOD rd/wr, PRESCALE_W bits
module custom_pio_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE_W  = 24
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  input  logic [WIDTH-1:0]  pio_in,
  output logic [WIDTH-1:0]  pio_out,
  output logic [WIDTH-1:0]  pio_oe,
  output logic              irq
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;
  localparam logic [2:0] ADDR_BEN    = 3'd6;
  localparam logic [2:0] ADDR_PERIOD = 3'd7;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_ff;
  logic [WIDTH-1:0]      sync_in;
  logic [WIDTH-1:0]      sync_d;
  logic [WIDTH-1:0]      out_reg;
  logic [WIDTH-1:0]      dir_reg;
  logic [WIDTH-1:0]      mask_reg;
  logic [WIDTH-1:0]      edge_reg;
  logic [WIDTH-1:0]      blink_en;
  logic [PRESCALE_W-1:0] blink_period;
  logic [PRESCALE_W-1:0] blink_cnt;

  logic [WIDTH-1:0]      wdata;
  logic                  wr_data, wr_dir, wr_mask, wr_edge;
  logic                  wr_set, wr_clr, wr_ben, wr_period;
  logic                  blink_active;
  logic                  tick;
  logic [WIDTH-1:0]      out_nxt;
  logic [WIDTH-1:0]      edge_nxt;
  logic [31:0]           rd_mux;

  // Register widths are narrower than the bus; the upper write-data bits
  // are deliberately discarded.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  assign wdata     = avs_writedata[WIDTH-1:0];
  assign wr_data   = avs_write && (avs_address == ADDR_DATA);
  assign wr_dir    = avs_write && (avs_address == ADDR_DIR);
  assign wr_mask   = avs_write && (avs_address == ADDR_MASK);
  assign wr_edge   = avs_write && (avs_address == ADDR_EDGE);
  assign wr_set    = avs_write && (avs_address == ADDR_OUTSET);
  assign wr_clr    = avs_write && (avs_address == ADDR_OUTCLR);
  assign wr_ben    = avs_write && (avs_address == ADDR_BEN);
  assign wr_period = avs_write && (avs_address == ADDR_PERIOD);

  assign sync_in = sync_ff[SYNC_STAGES-1];

  // Blink tick: counter runs 0..BLINK_PERIOD-1; tick on the last count.
  assign blink_active = (blink_period != '0) && (blink_en != '0);
  assign tick = blink_active && (blink_cnt == blink_period - PRESCALE_W'(1));

  // DATA write wins; otherwise set, then clear, then blink toggle.
  always_comb begin
    out_nxt = out_reg;
    if (wr_set) out_nxt = out_nxt | wdata;
    if (wr_clr) out_nxt = out_nxt & ~wdata;
    if (tick)   out_nxt = out_nxt ^ blink_en;
    if (wr_data) out_nxt = wdata;
  end

  // New rising edges take precedence over a same-cycle write-1-to-clear.
  always_comb begin
    edge_nxt = (edge_reg & ~(wr_edge ? wdata : '0)) | (sync_in & ~sync_d);
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA:   rd_mux[WIDTH-1:0]      = sync_in;
      ADDR_DIR:    rd_mux[WIDTH-1:0]      = dir_reg;
      ADDR_MASK:   rd_mux[WIDTH-1:0]      = mask_reg;
      ADDR_EDGE:   rd_mux[WIDTH-1:0]      = edge_reg;
      ADDR_BEN:    rd_mux[WIDTH-1:0]      = blink_en;
      ADDR_PERIOD: rd_mux[PRESCALE_W-1:0] = blink_period;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_ff <= '0;
      sync_d  <= '0;
    end else begin
      sync_ff[0] <= pio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_ff[i] <= sync_ff[i-1];
      sync_d <= sync_in;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_reg      <= '0;
      dir_reg      <= '0;
      mask_reg     <= '0;
      edge_reg     <= '0;
      blink_en     <= '0;
      blink_period <= '0;
      irq          <= 1'b0;
    end else begin
      out_reg  <= out_nxt;
      edge_reg <= edge_nxt;
      irq      <= |(edge_reg & mask_reg);
      if (wr_dir)    dir_reg      <= wdata;
      if (wr_mask)   mask_reg     <= wdata;
      if (wr_ben)    blink_en     <= wdata;
      if (wr_period) blink_period <= avs_writedata[PRESCALE_W-1:0];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      blink_cnt <= '0;
    end else if (!blink_active || wr_period || tick) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + PRESCALE_W'(1);
    end
  end

  // Read data is sampled before any same-cycle write lands.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      avs_readdata      <= avs_read ? rd_mux : '0;
    end
  end

  assign pio_out = out_reg;
  assign pio_oe  = dir_reg;

endmodule

// File: tb/tb_custom_pio_ctrl.sv
// Self-checking bench for custom_pio_ctrl: directed steps followed by
// random bus/pin traffic, compared each cycle against a behavioural model.
module tb_custom_pio_ctrl;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [7:0]  pio_in, pio_out, pio_oe;
  logic        irq;

  custom_pio_ctrl #(.WIDTH(8), .SYNC_STAGES(S), .PRESCALE_W(24)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .pio_in(pio_in), .pio_out(pio_out), .pio_oe(pio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // behavioural model state
  logic [7:0]  m_out, m_dir, m_mask, m_edge, m_ben;
  logic [23:0] m_per, m_cnt;
  logic        m_irq, m_rv;
  logic [31:0] m_rdat;
  logic [7:0]  hist [0:4];
  logic [7:0]  pin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_dir = 0; m_mask = 0; m_edge = 0; m_ben = 0;
    m_per = 0; m_cnt = 0; m_irq = 0; m_rv = 0; m_rdat = 0;
    for (int i = 0; i < 5; i++) hist[i] = 0;
  endtask

  function automatic logic tick_pending();
    return (m_per != 0) && (m_ben != 0) && (m_cnt == m_per - 24'd1);
  endfunction

  // One bus cycle: drive inputs, predict the next state, clock, compare.
  task automatic cycle(input logic rd, input logic wr, input logic [2:0] a,
                       input logic [31:0] wd);
    logic [7:0] sync, syncd, nout, nedge, w8;
    logic [31:0] rdat;
    logic [23:0] ncnt;
    logic tk, act, nirq;
    avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = wd;
    pio_in = pin;
    w8 = wd[7:0];
    sync = hist[S-1];
    syncd = hist[S];
    case (a)
      3'd0: rdat = {24'd0, sync};
      3'd1: rdat = {24'd0, m_dir};
      3'd2: rdat = {24'd0, m_mask};
      3'd3: rdat = {24'd0, m_edge};
      3'd6: rdat = {24'd0, m_ben};
      3'd7: rdat = {8'd0, m_per};
      default: rdat = 0;
    endcase
    act = (m_per != 0) && (m_ben != 0);
    tk = tick_pending();
    ncnt = (!act || tk || (wr && a == 3'd7)) ? 24'd0 : m_cnt + 24'd1;
    if (wr && a == 3'd0) nout = w8;
    else begin
      nout = m_out;
      if (wr && a == 3'd4) nout = nout | w8;
      if (wr && a == 3'd5) nout = nout & ~w8;
      if (tk) nout = nout ^ m_ben;
    end
    nedge = (m_edge & ~((wr && a == 3'd3) ? w8 : 8'd0)) | (sync & ~syncd);
    nirq = |(m_edge & m_mask);
    @(posedge clk);
    m_out = nout; m_edge = nedge; m_irq = nirq; m_cnt = ncnt;
    if (wr) begin
      case (a)
        3'd1: m_dir = w8;
        3'd2: m_mask = w8;
        3'd6: m_ben = w8;
        3'd7: m_per = wd[23:0];
        default: ;
      endcase
    end
    for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pin;
    m_rv = rd;
    m_rdat = rd ? rdat : 32'd0;
    @(negedge clk);
    chk("pio_out", {24'd0, pio_out}, {24'd0, m_out});
    chk("pio_oe", {24'd0, pio_oe}, {24'd0, m_dir});
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
    chk("readdatavalid", {31'd0, avs_readdatavalid}, {31'd0, m_rv});
    if (m_rv) chk("readdata", avs_readdata, m_rdat);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
    cycle(1'b0, 1'b1, a, wd);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    cycle(1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  initial begin
    logic rd, wr;
    logic [2:0] a;
    logic [31:0] wd;
    int guard;

    // reset
    rst_n = 1'b0; pin = 0;
    avs_read = 0; avs_write = 0; avs_address = 0; avs_writedata = 0; pio_in = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_pio_out", {24'd0, pio_out}, 32'h0);
    chk("rst_pio_oe", {24'd0, pio_oe}, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      rd_reg(3'(i));
      chk("rst_readback", avs_readdata, 32'h0);
    end

    // direction / data
    wr_reg(3'd1, 32'h0F);
    wr_reg(3'd0, 32'hA5);
    chk("dir_oe", {24'd0, pio_oe}, 32'h0F);
    chk("data_out", {24'd0, pio_out}, 32'hA5);
    pin = 8'h3C;
    idle(2);
    rd_reg(3'd0);
    chk("data_pin_read", avs_readdata, 32'h3C);
    idle(1);
    chk("rvalid_drop", {31'd0, avs_readdatavalid}, 32'h0);
    cycle(1'b1, 1'b1, 3'd1, 32'h33);
    chk("rd_wr_prewrite", avs_readdata, 32'h0F);

    // set / clear
    wr_reg(3'd0, 32'h00);
    wr_reg(3'd4, 32'h81);
    chk("outset", {24'd0, pio_out}, 32'h81);
    wr_reg(3'd5, 32'h01);
    chk("outclr", {24'd0, pio_out}, 32'h80);
    rd_reg(3'd4);
    chk("outset_reads0", avs_readdata, 32'h0);
    rd_reg(3'd5);
    chk("outclr_reads0", avs_readdata, 32'h0);

    // edge / irq
    pin = 0;
    idle(4);
    wr_reg(3'd3, 32'hFF);
    wr_reg(3'd2, 32'h04);
    pin = 8'h04;
    idle(4);
    chk("irq_bit2", {31'd0, irq}, 32'h1);
    rd_reg(3'd3);
    chk("edge_bit2", avs_readdata, 32'h04);
    wr_reg(3'd3, 32'h04);
    idle(1);
    chk("irq_cleared", {31'd0, irq}, 32'h0);
    pin = 8'h0C;
    idle(4);
    chk("irq_masked_bit3", {31'd0, irq}, 32'h0);
    rd_reg(3'd3);
    chk("edge_bit3", avs_readdata, 32'h08);
    pin = 8'h08;
    idle(4);
    pin = 8'h0C;
    idle(2);
    wr_reg(3'd3, 32'h04);
    rd_reg(3'd3);
    chk("edge_set_wins", avs_readdata, 32'h0C);

    // blink
    wr_reg(3'd2, 32'h00);
    wr_reg(3'd0, 32'h00);
    wr_reg(3'd7, 32'h4);
    wr_reg(3'd6, 32'h01);
    idle(10);
    wr_reg(3'd7, 32'h4);
    idle(9);
    wr_reg(3'd7, 32'h0);
    idle(6);

    // priority: DATA write on a tick
    wr_reg(3'd7, 32'h4);
    guard = 0;
    while (!tick_pending() && guard < 10) begin idle(1); guard++; end
    chk("tick_found_data", {31'd0, tick_pending()}, 32'h1);
    wr_reg(3'd0, 32'h5A);
    chk("data_beats_tick", {24'd0, pio_out}, 32'h5A);
    guard = 0;
    while (!(tick_pending() && m_out[0] == 1'b0) && guard < 20) begin idle(1); guard++; end
    chk("tick_found_set", {31'd0, tick_pending()}, 32'h1);
    wr_reg(3'd4, 32'h01);
    chk("outset_then_toggle", {31'd0, pio_out[0]}, 32'h0);

    // async reset mid-blink
    wr_reg(3'd1, 32'hFF);
    wr_reg(3'd7, 32'h3);
    wr_reg(3'd6, 32'hFF);
    idle(5);
    rd_reg(3'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_oe", {24'd0, pio_oe}, 32'h0);
    chk("async_rst_out", {24'd0, pio_out}, 32'h0);
    chk("async_rst_irq", {31'd0, irq}, 32'h0);
    chk("async_rst_rvalid", {31'd0, avs_readdatavalid}, 32'h0);
    model_reset();
    pin = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_reg(3'(i));
      chk("post_rst_readback", avs_readdata, 32'h0);
    end

    // random traffic
    for (int n = 0; n < 500; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 3) == 0);
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd7) wd = $urandom_range(0, 6);
      if ($urandom_range(0, 7) == 0) pin = 8'($urandom);
      cycle(rd, wr, a, wd);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
